bnn_layer1_seq: RTL and testbench
=================================

BNN_LAYER1_SEQ -- requirements
Module: bnn_layer1_seq

Interface
REQ-001 SHALL have parameter N_IN, default 64, meaning input vector width in bits.
REQ-002 SHALL have parameter N_OUT, default 50, meaning neuron count and output vector width (even).
REQ-003 SHALL have parameter CNT_W, default 7, meaning popcount and threshold width (holds 0..N_IN).
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port: cfg_we  input  1  weight/threshold write strobe.
REQ-007 SHALL have port: cfg_addr  input  6  neuron index to write.
REQ-008 SHALL have port: cfg_wdata  input  N_IN  weight row (1 = +1, 0 = -1).
REQ-009 SHALL have port: cfg_th  input  CNT_W  threshold for that neuron.
REQ-010 SHALL have port: in_valid  input  1  input vector valid.
REQ-011 SHALL have port: in_ready  output  1  block can accept input.
REQ-012 SHALL have port: in_data  input  N_IN  binarized input vector.
REQ-013 SHALL have port: out_valid  output  1  out_data valid.
REQ-014 SHALL have port: out_ready  input  1  downstream layer accepts out_data.
REQ-015 SHALL have port: out_data  output  N_OUT  binarized activations; feeds the 50-bit input of the next layer.
REQ-016 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1; in_valid&in_ready latches in_data, clears neuron index to 0, clears out_data, goes to RUN.
REQ-019 RUN: per cycle, neuron k SHALL compute popcount(weight[k] XNOR x) over N_IN bits, CNT_W wide, no overflow.
REQ-020 Bit k of out_data SHALL be 1 iff popcount > threshold[k] (strictly greater, unsigned); bit k written in the cycle neuron k is evaluated.
REQ-021 RUN SHALL process one neuron per cycle in index order 0..N_OUT-1; after index N_OUT-1, next state DONE.
REQ-022 Latency: handshake at cycle T -> out_valid high from cycle T+1+N_OUT (T+51 at defaults).
REQ-023 DONE: out_valid=1, out_data held stable until out_valid&out_ready; then IDLE next cycle.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid there is ignored, no data latched.
REQ-025 cfg_we in IDLE with cfg_addr < N_OUT SHALL write weight row and threshold at that index next edge.
REQ-026 cfg_we in RUN/DONE, or cfg_addr >= N_OUT, SHALL be ignored with no storage change.
REQ-027 cfg_we and in_valid accepted in the same IDLE cycle: the write SHALL complete before neuron evaluation uses it.
REQ-028 out_data SHALL not change outside RUN, except cleared on accept per REQ-018.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, neuron index 0, out_valid=0, out_data=0, busy=0, in_ready=1 from reset release.
REQ-030 Reset SHALL clear all weight rows and thresholds to 0.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abort; no partial result is presented after release.

Configuration
REQ-032 Macro BNN_L1_TWO_PER_CYCLE_EN defined: RUN SHALL evaluate neurons 2j and 2j+1 per cycle, N_OUT/2 cycles; out_valid from T+1+N_OUT/2 (T+26).
REQ-033 Macro undefined: one neuron per cycle per REQ-021/REQ-022; results bit-identical in both builds.

Verification
REQ-034 Reset: rst_n low 3 cycles -> out_valid=0, out_data=0, in_ready=1, busy=0.
REQ-035 All weights all-ones, thresholds 63, in_data all-ones -> out_data all-ones, out_valid rises exactly 51 cycles after accept (26 with macro).
REQ-036 Weights zero, in_data with exactly 30 zero bits, neuron 0 th=29, neuron 1 th=30 -> out_data[0]=1, out_data[1]=0.
REQ-037 out_ready low 10 cycles in DONE -> out_data stable, in_ready=0, concurrent in_valid pulse not accepted; out_ready high -> IDLE next cycle.
REQ-038 rst_n pulsed at RUN cycle 20 -> IDLE, out_valid stays 0, all thresholds and weights read back as 0 via subsequent all-zero-input result.
REQ-039 cfg write to neuron 3 during RUN -> ignored; result bit 3 matches pre-write weights.

Source files
------------

// File: rtl/bnn_layer1_seq.sv
// Sequential binarized dense layer: one XNOR-popcount neuron per cycle into a thresholded bit vector.
// Optional build macro BNN_L1_TWO_PER_CYCLE_EN evaluates two neurons per cycle (N_OUT must be even).
module bnn_layer1_seq #(
  parameter int unsigned N_IN  = 64,
  parameter int unsigned N_OUT = 50,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_addr,
  input  logic [N_IN-1:0]  cfg_wdata,
  input  logic [CNT_W-1:0] cfg_th,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             busy
);

`ifdef BNN_L1_TWO_PER_CYCLE_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_IN-1:0]  weight_q [N_OUT];
  logic [CNT_W-1:0] thresh_q [N_OUT];
  logic [N_IN-1:0]  x_q;
  logic [5:0]       idx_q;
  logic [5:0]       idx_d;
  logic [N_OUT-1:0] out_data_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             cfg_hit;
  logic             last_idx;
  logic             act0;
`ifdef BNN_L1_TWO_PER_CYCLE_EN
  logic [5:0]       idx1;
  logic             act1;
`endif

  // Number of positions where weight and input agree (XNOR popcount).
  function automatic logic [CNT_W-1:0] agree_cnt(input logic [N_IN-1:0] w,
                                                 input logic [N_IN-1:0] x);
    logic [N_IN-1:0]  m;
    logic [CNT_W-1:0] c;
    m = ~(w ^ x);
    c = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  always_comb begin
    cfg_hit  = cfg_we && (state_q == IDLE) && (32'(cfg_addr) < N_OUT);
    last_idx = (idx_q == 6'(N_OUT - STEP));
    idx_d    = idx_q + 6'(STEP);
    act0     = agree_cnt(weight_q[idx_q], x_q) > thresh_q[idx_q];
`ifdef BNN_L1_TWO_PER_CYCLE_EN
    idx1     = idx_q + 6'd1;
    act1     = agree_cnt(weight_q[idx1], x_q) > thresh_q[idx1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        weight_q[k] <= '0;
        thresh_q[k] <= '0;
      end
    end else begin
      // Storage writes land on the accept edge, so RUN always sees them.
      if (cfg_hit) begin
        weight_q[cfg_addr] <= cfg_wdata;
        thresh_q[cfg_addr] <= cfg_th;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= in_data;
            idx_q      <= '0;
            out_data_q <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          out_data_q[idx_q] <= act0;
`ifdef BNN_L1_TWO_PER_CYCLE_EN
          out_data_q[idx1]  <= act1;
`endif
          idx_q <= idx_d;
          if (last_idx) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bnn_layer1_seq.sv
// Self-checking bench for bnn_layer1_seq against a popcount/threshold reference model.
module tb_bnn_layer1_seq;
  localparam int N_IN  = 64;
  localparam int N_OUT = 50;
  localparam int CNT_W = 7;
`ifdef BNN_L1_TWO_PER_CYCLE_EN
  localparam int LAT = N_OUT / 2;
`else
  localparam int LAT = N_OUT;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_we = 1'b0;
  logic [5:0]       cfg_addr = '0;
  logic [N_IN-1:0]  cfg_wdata = '0;
  logic [CNT_W-1:0] cfg_th = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N_OUT-1:0] out_data;
  logic             busy;

  int total = 0;
  int bad = 0;

  logic [N_IN-1:0]  mw [N_OUT];
  logic [CNT_W-1:0] mt [N_OUT];

  bnn_layer1_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_th(cfg_th), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: neuron fires when the count of agreeing bits exceeds its threshold.
  function automatic logic [N_OUT-1:0] model(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] r;
    for (int k = 0; k < N_OUT; k++) begin
      r[k] = ($countones(~(mw[k] ^ x)) > int'(mt[k]));
    end
    return r;
  endfunction

  function automatic logic [N_IN-1:0] rnd_vec();
    return {$urandom, $urandom};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_OUT; k++) begin
      mw[k] = '0;
      mt[k] = '0;
    end
  endtask

  task automatic cfg_write(input int addr, input logic [N_IN-1:0] w, input int th);
    cfg_we    = 1'b1;
    cfg_addr  = 6'(addr);
    cfg_wdata = w;
    cfg_th    = CNT_W'(th);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < N_OUT) begin
      mw[addr] = w;
      mt[addr] = CNT_W'(th);
    end
  endtask

  task automatic start_vector(input logic [N_IN-1:0] x);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_rel got=%b exp=0", out_valid); end
  endtask

  task automatic test_all_ones();
    logic [N_OUT-1:0] exp;
    int lat;
    for (int k = 0; k < N_OUT; k++) cfg_write(k, '1, 63);
    exp = model('1);
    start_vector('1);
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL run_flags got busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
    wait_valid(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL all_ones_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (out_data !== exp || exp !== {N_OUT{1'b1}}) begin bad++; $display("FAIL all_ones_data got=%h exp=%h", out_data, exp); end
    release_out();
  endtask

  task automatic test_threshold_edge();
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] exp;
    int lat;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    x = '1;
    while ($countones(~x) < 30) x[$urandom_range(N_IN-1, 0)] = 1'b0;
    cfg_write(0, '0, 29);
    cfg_write(1, '0, 30);
    exp = model(x);
    start_vector(x);
    wait_valid(lat);
    total++; if (out_data[0] !== 1'b1) begin bad++; $display("FAIL th29_bit0 got=%b exp=1", out_data[0]); end
    total++; if (out_data[1] !== 1'b0) begin bad++; $display("FAIL th30_bit1 got=%b exp=0", out_data[1]); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL th_edge_data got=%h exp=%h", out_data, exp); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [N_OUT-1:0] exp;
    logic [N_OUT-1:0] held;
    int lat;
    int errs;
    for (int k = 0; k < N_OUT; k++) cfg_write(k, rnd_vec(), $urandom_range(26, 38));
    exp = model(rnd_vec());
    in_data = '0;
    start_vector(in_data);
    exp = model('0);
    wait_valid(lat);
    held = out_data;
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin in_valid = 1'b1; in_data = rnd_vec(); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL done_hold errors=%0d exp=0", errs); end
    total++; if (held !== exp) begin bad++; $display("FAIL bp_data got=%h exp=%h", held, exp); end
    release_out();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_exit got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy); end
    repeat (3) @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_pulse_accepted got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [N_OUT-1:0] exp;
    int lat;
    int seen;
    for (int k = 0; k < N_OUT; k++) cfg_write(k, rnd_vec(), $urandom_range(0, 63));
    start_vector(rnd_vec());
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL async_abort got out_valid=%b busy=%b in_ready=%b exp 0 0 1", out_valid, busy, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_valid got=%0d cycles exp=0", seen); end
    exp = model('0);
    start_vector('0);
    wait_valid(lat);
    total++; if (out_data !== exp) begin bad++; $display("FAIL cleared_storage got=%h exp=%h", out_data, exp); end
    release_out();
  endtask

  task automatic test_cfg_during_run();
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] exp;
    int lat;
    x = rnd_vec();
    cfg_write(3, x, 60);
    exp = model(x);
    start_vector(x);
    repeat (2) @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_addr = 6'd3; cfg_wdata = ~x; cfg_th = '0;
    in_valid = 1'b1; in_data = ~x;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_valid(lat);
    cfg_we = 1'b1; cfg_addr = 6'd3; cfg_wdata = ~x; cfg_th = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    total++; if (out_data[3] !== 1'b1) begin bad++; $display("FAIL run_cfg_bit3 got=%b exp=1", out_data[3]); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL run_cfg_data got=%h exp=%h", out_data, exp); end
    release_out();
    exp = model(x);
    start_vector(x);
    wait_valid(lat);
    total++; if (out_data !== exp) begin bad++; $display("FAIL done_cfg_data got=%h exp=%h", out_data, exp); end
    release_out();
  endtask

  task automatic test_same_cycle();
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] exp;
    int lat;
    x = rnd_vec();
    cfg_write(0, ~x, 63);
    cfg_write(55, '1, 0);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = x; cfg_th = 7'd63;
    in_valid = 1'b1; in_data = x;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    mw[0] = x; mt[0] = 7'd63;
    exp = model(x);
    wait_valid(lat);
    total++; if (out_data[0] !== 1'b1) begin bad++; $display("FAIL same_cycle_bit0 got=%b exp=1", out_data[0]); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL same_cycle_data got=%h exp=%h", out_data, exp); end
    release_out();
  endtask

  task automatic test_random();
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] exp;
    int lat;
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 12; j++) cfg_write($urandom_range(N_OUT - 1, 0), rnd_vec(), $urandom_range(24, 40));
      x = rnd_vec();
      exp = model(x);
      start_vector(x);
      wait_valid(lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, LAT); end
      total++; if (out_data !== exp) begin bad++; $display("FAIL rand_data it=%0d got=%h exp=%h", it, out_data, exp); end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_threshold_edge();
    test_backpressure();
    test_reset_mid_run();
    test_cfg_during_run();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
